// File: rtl/sh4a_mac_unit.sv
// SH4A MAC datapath (MUL/MAC/CLR/LOAD on MACH:MACL); acc updates LAT cycles after issue.
// No backpressure: one op accepted and one retired per cycle, strictly in order.
module sh4a_mac_unit #(
  parameter int WIDTH      = 32,
  parameter int ACC_W      = 64,
  parameter int LAT        = 2,
  parameter int SATW_SHORT = 32,
  parameter int SATW_LONG  = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         op,
  input  logic               op_signed,
  input  logic               sat_en,
  input  logic               sat_long,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [ACC_W-1:0]   load_data,
  output logic [ACC_W-1:0]   acc,
  output logic               out_valid,
  output logic               sat_hit,
  output logic               busy
);

  localparam int NST = LAT - 1;
  localparam int PW  = 2 * WIDTH;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  typedef struct packed {
    logic             vld;
    logic [1:0]       op;
    logic             sgn;
    logic             sat_en;
    logic             sat_long;
    logic [ACC_W-1:0] load;
    logic [PW-1:0]    prod;
  } stage_t;

  stage_t pipe_q [NST];
  stage_t pipe_d [NST];

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_hit_q, sat_hit_d;

  // Operands are extended to the product width so one unsigned multiply
  // yields the correct low 2*WIDTH bits for both signed and unsigned ops.
  logic [PW-1:0] a_x, b_x, prod;
  assign a_x  = {{WIDTH{op_signed & src_a[WIDTH-1]}}, src_a};
  assign b_x  = {{WIDTH{op_signed & src_b[WIDTH-1]}}, src_b};
  assign prod = a_x * b_x;

  always_comb begin
    pipe_d = pipe_q;
    pipe_d[0].vld = in_valid;
    if (in_valid) begin
      pipe_d[0].op       = op;
      pipe_d[0].sgn      = op_signed;
      pipe_d[0].sat_en   = sat_en;
      pipe_d[0].sat_long = sat_long;
      pipe_d[0].load     = load_data;
      pipe_d[0].prod     = prod;
    end
    for (int i = 1; i < NST; i++) begin
      pipe_d[i].vld = pipe_q[i-1].vld;
      if (pipe_q[i-1].vld) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NST; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < NST; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  stage_t                  last;
  logic signed [PW-1:0]    prod_s;
  logic [ACC_W-1:0]        prod_ext;
  logic [ACC_W+1:0]        sum_w, sat_max, sat_min;
  int                      sat_sh;

  assign last     = pipe_q[NST-1];
  assign prod_s   = last.prod;
  assign prod_ext = last.sgn ? ACC_W'(prod_s) : ACC_W'(last.prod);

  // Two guard bits keep the signed sum exact for the clamp comparison.
  assign sum_w   = {{2{acc_q[ACC_W-1]}}, acc_q}
                 + {{2{last.sgn & prod_ext[ACC_W-1]}}, prod_ext};
  assign sat_sh  = last.sat_long ? SATW_LONG - 1 : SATW_SHORT - 1;
  assign sat_max = ((ACC_W+2)'(1) << sat_sh) - (ACC_W+2)'(1);
  assign sat_min = ~sat_max;

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = last.vld;
    sat_hit_d   = 1'b0;
    if (last.vld) begin
      case (last.op)
        OP_MUL: acc_d = prod_ext;
        OP_MAC: begin
          if (last.sat_en && ($signed(sum_w) > $signed(sat_max))) begin
            acc_d     = sat_max[ACC_W-1:0];
            sat_hit_d = 1'b1;
          end else if (last.sat_en && ($signed(sum_w) < $signed(sat_min))) begin
            acc_d     = sat_min[ACC_W-1:0];
            sat_hit_d = 1'b1;
          end else begin
            acc_d = sum_w[ACC_W-1:0];
          end
        end
        OP_CLR:  acc_d = '0;
        default: acc_d = last.load;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      sat_hit_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      sat_hit_q   <= sat_hit_d;
    end
  end

  // The retire stage counts as in flight, so busy drops the cycle after it.
  always_comb begin
    busy = out_valid_q;
    for (int i = 0; i < NST; i++) busy = busy | pipe_q[i].vld;
  end

  assign acc       = acc_q;
  assign out_valid = out_valid_q;
  assign sat_hit   = sat_hit_q;

endmodule

// File: tb/tb_sh4a_mac_unit.sv
// Scoreboard bench for sh4a_mac_unit: directed ops on a LAT=2 unit plus a LAT=4 unit.
module tb_sh4a_mac_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        op_signed = 1'b0, sat_en = 1'b0, sat_long = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic [63:0] load_data = '0;
  logic [63:0] acc;
  logic        out_valid, sat_hit, busy;

  logic        v4 = 1'b0;
  logic [1:0]  op4 = 2'b00;
  logic [31:0] a4 = '0, b4 = '0;
  logic [63:0] ld4 = '0;
  logic [63:0] acc4;
  logic        out_valid4, sat_hit4, busy4;

  always #5 clk = ~clk;

  sh4a_mac_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .op_signed(op_signed),
    .sat_en(sat_en), .sat_long(sat_long), .src_a(src_a), .src_b(src_b),
    .load_data(load_data), .acc(acc), .out_valid(out_valid), .sat_hit(sat_hit), .busy(busy)
  );

  sh4a_mac_unit #(.LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .op(op4), .op_signed(1'b0),
    .sat_en(1'b0), .sat_long(1'b0), .src_a(a4), .src_b(b4),
    .load_data(ld4), .acc(acc4), .out_valid(out_valid4), .sat_hit(sat_hit4), .busy(busy4)
  );

  typedef struct packed {
    logic [63:0] acc;
    logic        hit;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic s, input logic se, input logic sl,
                       input logic [31:0] a, input logic [31:0] b, input logic [63:0] ld);
    @(negedge clk);
    in_valid = 1'b1; op = o; op_signed = s; sat_en = se; sat_long = sl;
    src_a = a; src_b = b; load_data = ld;
  endtask

  task automatic issue(input string nm, input logic [1:0] o, input logic s, input logic se,
                       input logic sl, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ld, input logic [63:0] ea, input logic eh);
    exp_t e;
    drive(o, s, se, sl, a, b, ld);
    e.acc = ea;
    e.hit = eh;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Garbage on the data inputs while idle must not disturb anything.
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; op = 2'b01; sat_en = 1'b1;
    src_a = $urandom; src_b = $urandom; load_data = {$urandom, $urandom};
  endtask

  // Monitor: pops one expectation per retirement.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got acc %h expected no retirement", acc);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, "_acc"}, acc, e.acc);
          chk({nm, "_sat_hit"}, {63'b0, sat_hit}, {63'b0, e.hit});
        end
      end else if (sat_hit) begin
        checks++;
        errors++;
        $display("FAIL sat_hit_without_retire: got 1 expected 0");
      end
    end
  end

  initial begin
    int cnt;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_acc", acc, 64'h0);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-stream discards the in-flight MAC.
    issue("pre_rst_load", 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h55, 64'h55, 1'b0);
    drive(2'b01, 1'b0, 1'b0, 1'b0, 32'h1, 32'h1, 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", acc, 64'h0);
    chk("midrst_busy", {63'b0, busy}, 64'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    issue("mul_s", 2'b00, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h2, 64'h0, 64'hFFFFFFFF_FFFFFFFE, 1'b0);
    issue("mul_u", 2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h2, 64'h0, 64'h00000001_FFFFFFFE, 1'b0);
    idle();

    issue("b2b_load", 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'd10, 64'd10, 1'b0);
    issue("b2b_mac1", 2'b01, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 64'h0, 64'd22, 1'b0);
    issue("b2b_mac2", 2'b01, 1'b0, 1'b0, 1'b0, 32'd5, 32'd6, 64'h0, 64'd52, 1'b0);
    idle();
    @(posedge clk);
    #1;
    chk("busy_at_last_retire", {63'b0, busy}, 64'h1);
    @(posedge clk);
    #1;
    chk("busy_after_last_retire", {63'b0, busy}, 64'h0);

    issue("ss_load", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 64'h7FFFFFF0, 64'h7FFFFFF0, 1'b0);
    issue("ss_pos", 2'b01, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1, 64'h0, 64'h00000000_7FFFFFFF, 1'b1);
    issue("ss_load2", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 64'hFFFFFFFF_80000005,
          64'hFFFFFFFF_80000005, 1'b0);
    issue("ss_neg", 2'b01, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF0, 32'h1, 64'h0, 64'hFFFFFFFF_80000000, 1'b1);
    issue("ss_uload", 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0, 1'b0);
    issue("ss_unsigned", 2'b01, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, 64'h0, 64'h00000000_7FFFFFFF, 1'b1);

    issue("sl_load", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 64'h00007FFF_FFFFFFFF,
          64'h00007FFF_FFFFFFFF, 1'b0);
    issue("sl_sat", 2'b01, 1'b1, 1'b1, 1'b1, 32'h1, 32'h1, 64'h0, 64'h00007FFF_FFFFFFFF, 1'b1);
    issue("sl_load2", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 64'h00007FFF_FFFFFFFF,
          64'h00007FFF_FFFFFFFF, 1'b0);
    issue("sl_nosat", 2'b01, 1'b1, 1'b0, 1'b1, 32'h1, 32'h1, 64'h0, 64'h00008000_00000000, 1'b0);
    issue("wrap_load", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 64'h7FFFFFFF_FFFFFFFF,
          64'h7FFFFFFF_FFFFFFFF, 1'b0);
    issue("wrap_mac", 2'b01, 1'b1, 1'b0, 1'b0, 32'h1, 32'h1, 64'h0, 64'h80000000_00000000, 1'b0);
    idle();
    idle();

    issue("ord_load", 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'd5, 64'd5, 1'b0);
    issue("ord_mac1", 2'b01, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 64'h0, 64'd11, 1'b0);
    issue("ord_clr", 2'b10, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 64'h0, 64'd0, 1'b0);
    issue("ord_mac2", 2'b01, 1'b0, 1'b0, 1'b0, 32'd4, 32'd4, 64'h0, 64'd16, 1'b0);
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    // LAT=4 unit: retirement latency.
    @(negedge clk);
    v4 = 1'b1; op4 = 2'b11; ld4 = 64'h1234;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      v4 = 1'b0;
      cnt++;
      if (out_valid4) break;
    end
    chk("lat4_latency", 64'(cnt), 64'd4);
    chk("lat4_acc", acc4, 64'h1234);

    // LAT=4 unit: reset with three MACs in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v4 = 1'b1; op4 = 2'b01; a4 = 32'h1; b4 = 32'h1;
    end
    @(negedge clk);
    v4 = 1'b0;
    chk("lat4_busy_inflight", {63'b0, busy4}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("lat4_rst_acc", acc4, 64'h0);
    chk("lat4_rst_busy", {63'b0, busy4}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid4) cnt++;
    end
    chk("lat4_no_retire_after_rst", 64'(cnt), 64'd0);
    chk("lat4_acc_after_rst", acc4, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
